// File: rtl/avr_io_timer_cmp.sv
// AVR-style timer with a byte-wide register port, TMP-latched 16-bit access,
// a 12-bit prescaler, CTC wrap, two compare channels and registered PWM outputs.
module avr_io_timer_cmp #(
  parameter int                   CNT_WIDTH = 16,
  parameter logic [CNT_WIDTH-1:0] TOP_RESET = '1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_re,
  input  logic       io_we,
  input  logic [2:0] io_a,
  input  logic [7:0] io_di,
  output logic [7:0] io_do,
  output logic       irq,
  output logic [1:0] pwm
);

  typedef enum logic [2:0] {
    ADDR_CNTL  = 3'd0,
    ADDR_TMP   = 3'd1,
    ADDR_TCR   = 3'd2,
    ADDR_TSR   = 3'd3,
    ADDR_OCR0L = 3'd4,
    ADDR_OCR1L = 3'd5,
    ADDR_TOPL  = 3'd6,
    ADDR_RSVD  = 3'd7
  } addr_e;

  typedef struct packed {
    logic       ovie;
    logic       oc1ie;
    logic       oc0ie;
    logic       run;
    logic       ctc;
    logic       pwmen;
    logic [1:0] prescale;
  } tcr_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam bit                   HAS_TMP = (CNT_WIDTH > 8);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]           tmp_q, tmp_d;
  tcr_t                 tcr_q, tcr_d;
  logic [2:0]           flags_q, flags_d;   // {OVF, OC1F, OC0F}, aligned with TSR[7:5]
  logic [CNT_WIDTH-1:0] ocr0_q, ocr0_d;
  logic [CNT_WIDTH-1:0] ocr1_q, ocr1_d;
  logic [CNT_WIDTH-1:0] top_q, top_d;
  logic [11:0]          presc_q, presc_d;
  logic [2:0]           hist_q, hist_d;     // previous values of prescaler bits 11, 7, 3
  logic [1:0]           pwm_q, pwm_d;

  addr_e                addr;
  logic                 wr_en;
  logic                 wr_cntl;
  logic [15:0]          wr_word;
  logic [CNT_WIDTH-1:0] wr_val;
  logic [15:0]          cnt_ext;
  logic                 tick_src;
  logic                 tick;
  logic [CNT_WIDTH-1:0] top_eff;
  logic                 wrap;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 ov_set, oc0_set, oc1_set;

  assign addr    = addr_e'(io_a);
  assign wr_en   = io_we & ~io_re;
  assign wr_cntl = wr_en & (addr == ADDR_CNTL);
  assign wr_word = {tmp_q, io_di};
  assign wr_val  = wr_word[CNT_WIDTH-1:0];
  assign cnt_ext = 16'(cnt_q);

  always_comb begin
    tick_src = 1'b1;
    case (tcr_q.prescale)
      2'b01:   tick_src = hist_q[0] & ~presc_q[3];
      2'b10:   tick_src = hist_q[1] & ~presc_q[7];
      2'b11:   tick_src = hist_q[2] & ~presc_q[11];
      default: tick_src = 1'b1;
    endcase
  end

  // A CNTL write owns the counter for its cycle, so it masks the tick.
  assign tick     = tcr_q.run & tick_src & ~wr_cntl;
  assign top_eff  = tcr_q.ctc ? top_q : CNT_MAX;
  assign wrap     = (cnt_q >= top_eff);
  assign cnt_next = wrap ? '0 : cnt_q + CNT_ONE;
  assign ov_set   = tick & wrap;
  assign oc0_set  = tick & (cnt_next == ocr0_q);
  assign oc1_set  = tick & (cnt_next == ocr1_q);

  always_comb begin
    // NOTE: every next-state value defaults to its register so no path infers a latch.
    cnt_d   = cnt_q;
    tmp_d   = tmp_q;
    tcr_d   = tcr_q;
    flags_d = flags_q;
    ocr0_d  = ocr0_q;
    ocr1_d  = ocr1_q;
    top_d   = top_q;
    presc_d = presc_q + 12'd1;
    hist_d  = {presc_q[11], presc_q[7], presc_q[3]};

    if (io_re && (addr == ADDR_CNTL) && HAS_TMP) tmp_d = cnt_ext[15:8];

    if (wr_en) begin
      case (addr)
        ADDR_CNTL: begin
          cnt_d   = wr_val;
          presc_d = '0;
          hist_d  = '0;
        end
        ADDR_TMP:   if (HAS_TMP) tmp_d = io_di;
        ADDR_TCR:   tcr_d   = tcr_t'(io_di);
        ADDR_TSR:   flags_d = flags_q & ~io_di[7:5];
        ADDR_OCR0L: ocr0_d  = wr_val;
        ADDR_OCR1L: ocr1_d  = wr_val;
        ADDR_TOPL:  top_d   = wr_val;
        default:    ;
      endcase
    end

    if (tick) cnt_d = cnt_next;

    // Hardware set is applied after the W1C clear so it wins a collision.
    flags_d = flags_d | {ov_set, oc1_set, oc0_set};

    pwm_d[0] = tcr_q.pwmen & (cnt_q < ocr0_q);
    pwm_d[1] = tcr_q.pwmen & (cnt_q < ocr1_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      tmp_q   <= '0;
      tcr_q   <= '0;
      flags_q <= '0;
      ocr0_q  <= '0;
      ocr1_q  <= '0;
      top_q   <= TOP_RESET;
      presc_q <= '0;
      hist_q  <= '0;
      pwm_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      tmp_q   <= tmp_d;
      tcr_q   <= tcr_d;
      flags_q <= flags_d;
      ocr0_q  <= ocr0_d;
      ocr1_q  <= ocr1_d;
      top_q   <= top_d;
      presc_q <= presc_d;
      hist_q  <= hist_d;
      pwm_q   <= pwm_d;
    end
  end

  always_comb begin
    io_do = 8'h00;
    if (io_re) begin
      case (addr)
        ADDR_CNTL:  io_do = cnt_ext[7:0];
        ADDR_TMP:   io_do = tmp_q;
        ADDR_TCR:   io_do = tcr_q;
        ADDR_TSR:   io_do = {flags_q, 5'b0};
        ADDR_OCR0L: io_do = ocr0_q[7:0];
        ADDR_OCR1L: io_do = ocr1_q[7:0];
        ADDR_TOPL:  io_do = top_q[7:0];
        default:    io_do = 8'h00;
      endcase
    end
  end

  assign irq = (flags_q[2] & tcr_q.ovie) | (flags_q[1] & tcr_q.oc1ie) | (flags_q[0] & tcr_q.oc0ie);
  assign pwm = pwm_q;

endmodule

// File: tb/tb_avr_io_timer_cmp.sv
// Self-checking bench for avr_io_timer_cmp: directed scenarios plus a randomized
// run against an arithmetic reference model of the 16-bit timer.
module tb_avr_io_timer_cmp;

  logic       clk = 1'b0;
  logic       rst;
  logic       io_re, io_we;
  logic [2:0] io_a;
  logic [7:0] io_di;
  logic [7:0] do16, do8;
  logic       irq16, irq8;
  logic [1:0] pwm16, pwm8;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] s_do16, s_do8;
  logic       s_irq16;
  logic [1:0] s_pwm16, s_pwm8;

  // Reference model state for the 16-bit instance.
  int unsigned m_cnt, m_tmp, m_tcr, m_tsr, m_ocr0, m_ocr1, m_top;
  int          m_elapsed;
  logic [1:0]  m_pwm;

  avr_io_timer_cmp dut16 (
    .clk(clk), .rst(rst), .io_re(io_re), .io_we(io_we), .io_a(io_a), .io_di(io_di),
    .io_do(do16), .irq(irq16), .pwm(pwm16)
  );

  avr_io_timer_cmp #(.CNT_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .io_re(io_re), .io_we(io_we), .io_a(io_a), .io_di(io_di),
    .io_do(do8), .irq(irq8), .pwm(pwm8)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return 8'(m_cnt & 32'hFF);
      3'd1:    return 8'(m_tmp);
      3'd2:    return 8'(m_tcr);
      3'd3:    return 8'(m_tsr);
      3'd4:    return 8'(m_ocr0 & 32'hFF);
      3'd5:    return 8'(m_ocr1 & 32'hFF);
      3'd6:    return 8'(m_top & 32'hFF);
      default: return 8'h00;
    endcase
  endfunction

  // TSR flag bits and TCR enable bits share positions 7:5.
  function automatic logic m_irq();
    return ((m_tsr & m_tcr & 32'hE0) != 0);
  endfunction

  task automatic model_update();
    int unsigned word, nxt, top_eff, div;
    bit          wr, cntl_wr, tick;
    logic [1:0]  pwm_n;
    if (rst) begin
      m_cnt = 0; m_tmp = 0; m_tcr = 0; m_tsr = 0; m_ocr0 = 0; m_ocr1 = 0;
      m_top = 32'hFFFF; m_elapsed = 0; m_pwm = 2'b00;
      return;
    end
    pwm_n[0] = ((m_tcr & 32'h04) != 0) && (m_cnt < m_ocr0);
    pwm_n[1] = ((m_tcr & 32'h04) != 0) && (m_cnt < m_ocr1);
    wr       = io_we && !io_re;
    cntl_wr  = wr && (io_a == 3'd0);
    word     = (m_tmp << 8) | 32'(io_di);
    div      = 32'd1 << (4 * (m_tcr & 32'h3));
    tick     = ((m_tcr & 32'h10) != 0) && !cntl_wr &&
               (div == 1 || (m_elapsed > 0 && (m_elapsed % div) == 0));
    top_eff  = ((m_tcr & 32'h08) != 0) ? m_top : 32'hFFFF;
    if (io_re && io_a == 3'd0) m_tmp = m_cnt >> 8;
    if (wr && io_a == 3'd3) m_tsr = m_tsr & ~32'(io_di) & 32'hE0;
    if (tick) begin
      if (m_cnt >= top_eff) begin
        nxt   = 0;
        m_tsr = m_tsr | 32'h80;
      end else begin
        nxt = m_cnt + 1;
      end
      if (nxt == m_ocr0) m_tsr = m_tsr | 32'h20;
      if (nxt == m_ocr1) m_tsr = m_tsr | 32'h40;
      m_cnt = nxt;
    end
    if (wr) begin
      case (io_a)
        3'd0: m_cnt  = word;
        3'd1: m_tmp  = 32'(io_di);
        3'd2: m_tcr  = 32'(io_di);
        3'd4: m_ocr0 = word;
        3'd5: m_ocr1 = word;
        3'd6: m_top  = word;
        default: ;
      endcase
    end
    m_elapsed = cntl_wr ? 0 : m_elapsed + 1;
    m_pwm     = pwm_n;
  endtask

  task automatic sample();
    s_do16  = do16;
    s_do8   = do8;
    s_irq16 = irq16;
    s_pwm16 = pwm16;
    s_pwm8  = pwm8;
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_update();
    #1;
    io_re = 1'b0;
    io_we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    io_re = 1'b0; io_we = 1'b1; io_a = a; io_di = d;
    #1; sample();
    edge_step();
  endtask

  task automatic rd(input logic [2:0] a);
    io_re = 1'b1; io_we = 1'b0; io_a = a;
    #1; sample();
    edge_step();
  endtask

  task automatic idle();
    io_re = 1'b0; io_we = 1'b0;
    #1; sample();
    edge_step();
  endtask

  task automatic do_reset();
    rst = 1'b1; io_re = 1'b0; io_we = 1'b0;
    #1;
    edge_step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] addrs [8] = '{3'd2, 3'd3, 3'd1, 3'd0, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [7:0] exps  [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
    // Reset arrives together with a TCR write; reset must win.
    rst = 1'b1; io_we = 1'b1; io_re = 1'b0; io_a = 3'd2; io_di = 8'hFF;
    #1;
    edge_step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(addrs[i]);
      n_cmp++;
      if (s_do16 !== exps[i]) begin
        n_err++;
        $display("FAIL reset_reg a=%0d: got %h expected %h", addrs[i], s_do16, exps[i]);
      end
    end
    n_cmp++;
    if (s_irq16 !== 1'b0 || s_pwm16 !== 2'b00) begin
      n_err++;
      $display("FAIL reset_outputs: got irq=%b pwm=%b expected irq=0 pwm=00", s_irq16, s_pwm16);
    end
    rd(3'd6);
    n_cmp++;
    if (s_do8 !== 8'hFF) begin
      n_err++;
      $display("FAIL reset_top8: got %h expected ff", s_do8);
    end
    wr(3'd2, 8'h04);
    io_a = 3'd2; io_re = 1'b0; #1;
    n_cmp++;
    if (do16 !== 8'h00) begin
      n_err++;
      $display("FAIL idle_bus: got %h expected 00", do16);
    end
    edge_step();
  endtask

  task automatic test_ctc_wrap();
    logic [7:0] got;
    do_reset();
    wr(3'd1, 8'h00);
    wr(3'd6, 8'h04);
    wr(3'd0, 8'h00);
    wr(3'd2, 8'h98);
    for (int k = 0; k < 6; k++) begin
      rd(3'd0);
      n_cmp++;
      if (s_do16 !== 8'(k % 5) || s_irq16 !== (k == 5)) begin
        n_err++;
        $display("FAIL ctc_seq k=%0d: got cnt=%h irq=%b expected cnt=%h irq=%b",
                 k, s_do16, s_irq16, 8'(k % 5), (k == 5));
      end
    end
    wr(3'd2, 8'h88);
    rd(3'd3);
    got = s_do16;
    n_cmp++;
    if (got !== 8'hE0) begin
      n_err++;
      $display("FAIL ctc_tsr: got %h expected e0", got);
    end
    wr(3'd3, 8'h80);
    rd(3'd3);
    n_cmp++;
    if (s_do16 !== 8'h60 || s_irq16 !== 1'b0) begin
      n_err++;
      $display("FAIL ctc_w1c: got tsr=%h irq=%b expected tsr=60 irq=0", s_do16, s_irq16);
    end
  endtask

  task automatic test_atomic16();
    logic [7:0] exps [6] = '{8'hFF, 8'h12, 8'hCD, 8'hAB, 8'hCF, 8'hD0};
    logic [7:0] got  [6];
    do_reset();
    wr(3'd2, 8'h10);
    wr(3'd1, 8'h12);
    wr(3'd0, 8'hFF);
    rd(3'd0); got[0] = s_do16;
    rd(3'd1); got[1] = s_do16;
    wr(3'd1, 8'hAB);
    wr(3'd0, 8'hCD);
    rd(3'd0); got[2] = s_do16;
    rd(3'd1); got[3] = s_do16;
    // Simultaneous read and write of CNTL: the write must be dropped.
    io_re = 1'b1; io_we = 1'b1; io_a = 3'd0; io_di = 8'h00;
    #1; sample(); got[4] = s_do16;
    edge_step();
    rd(3'd0); got[5] = s_do16;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (got[i] !== exps[i]) begin
        n_err++;
        $display("FAIL atomic16 step=%0d: got %h expected %h", i, got[i], exps[i]);
      end
    end
  endtask

  task automatic test_prescaler();
    int exp_cnt;
    do_reset();
    wr(3'd2, 8'h11);
    wr(3'd1, 8'h00);
    wr(3'd0, 8'h00);
    // CNT holds 0 for the 16 clocks after the write edge, then steps every 16.
    for (int k = 0; k < 50; k++) begin
      exp_cnt = (k == 0) ? 0 : (k - 1) / 16;
      rd(3'd0);
      n_cmp++;
      if (s_do16 !== 8'(exp_cnt)) begin
        n_err++;
        $display("FAIL prescale k=%0d: got %h expected %h", k, s_do16, 8'(exp_cnt));
      end
    end
  endtask

  task automatic test_pwm();
    int h0, h1;
    do_reset();
    wr(3'd1, 8'h55);
    rd(3'd1);
    n_cmp++;
    if (s_do8 !== 8'h00 || s_do16 !== 8'h55) begin
      n_err++;
      $display("FAIL tmp_width: got w8=%h w16=%h expected w8=00 w16=55", s_do8, s_do16);
    end
    do_reset();
    wr(3'd4, 8'h40);
    wr(3'd5, 8'h00);
    wr(3'd2, 8'h14);
    idle(); idle(); idle();
    h0 = 0; h1 = 0;
    for (int i = 0; i < 256; i++) begin
      idle();
      h0 += int'(s_pwm8[0]);
      h1 += int'(s_pwm8[1]);
    end
    n_cmp++;
    if (h0 != 64) begin
      n_err++;
      $display("FAIL pwm0_duty: got %0d high of 256 expected 64", h0);
    end
    n_cmp++;
    if (h1 != 0) begin
      n_err++;
      $display("FAIL pwm1_zero: got %0d high of 256 expected 0", h1);
    end
  endtask

  task automatic test_flag_collision();
    do_reset();
    wr(3'd1, 8'h00);
    wr(3'd4, 8'h05);
    wr(3'd2, 8'h30);
    wr(3'd0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      rd(3'd3);
      n_cmp++;
      if (s_do16 !== 8'h00 || s_irq16 !== 1'b0) begin
        n_err++;
        $display("FAIL oc0_early k=%0d: got tsr=%h irq=%b expected tsr=00 irq=0", k, s_do16, s_irq16);
      end
    end
    wr(3'd3, 8'h20);
    rd(3'd3);
    n_cmp++;
    if (s_do16 !== 8'h20 || s_irq16 !== 1'b1) begin
      n_err++;
      $display("FAIL oc0_collision: got tsr=%h irq=%b expected tsr=20 irq=1", s_do16, s_irq16);
    end
    wr(3'd3, 8'h20);
    rd(3'd3);
    n_cmp++;
    if (s_do16 !== 8'h00 || s_irq16 !== 1'b0) begin
      n_err++;
      $display("FAIL oc0_clear: got tsr=%h irq=%b expected tsr=00 irq=0", s_do16, s_irq16);
    end
  endtask

  task automatic test_reset_mid_count();
    logic [2:0] addrs [5] = '{3'd1, 3'd0, 3'd3, 3'd6, 3'd2};
    logic [7:0] exps  [5] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
    do_reset();
    wr(3'd1, 8'h02);
    wr(3'd4, 8'h00);
    wr(3'd1, 8'hFF);
    wr(3'd0, 8'hFE);
    wr(3'd2, 8'hF4);
    idle(); idle(); idle();
    wr(3'd1, 8'h01);
    wr(3'd0, 8'h00);
    // CNT is now 0x0100 with OVF and OC1F pending; reset collides with a TCR write.
    rst = 1'b1; io_we = 1'b1; io_re = 1'b0; io_a = 3'd2; io_di = 8'hFF;
    #1;
    n_cmp++;
    if (irq16 !== 1'b1 || pwm16 !== 2'b01) begin
      n_err++;
      $display("FAIL pre_reset: got irq=%b pwm=%b expected irq=1 pwm=01", irq16, pwm16);
    end
    edge_step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd(addrs[i]);
      n_cmp++;
      if (s_do16 !== exps[i] || s_irq16 !== 1'b0 || s_pwm16 !== 2'b00) begin
        n_err++;
        $display("FAIL mid_reset a=%0d: got %h irq=%b pwm=%b expected %h irq=0 pwm=00",
                 addrs[i], s_do16, s_irq16, s_pwm16, exps[i]);
      end
    end
  endtask

  task automatic test_random();
    int r;
    logic [7:0] exp_do;
    do_reset();
    wr(3'd2, 8'h1C);
    for (int i = 0; i < 3000; i++) begin
      r     = int'($urandom_range(0, 99));
      io_a  = 3'($urandom_range(0, 7));
      io_di = 8'($urandom_range(0, 255));
      io_re = (r < 35) || (r >= 95);
      io_we = (r >= 60);
      if (io_we && io_a == 3'd2 && $urandom_range(0, 7) != 0) io_di[4] = 1'b1;
      rst = ($urandom_range(0, 999) == 0);
      #1;
      exp_do = io_re ? m_read(io_a) : 8'h00;
      n_cmp++;
      if (do16 !== exp_do) begin
        n_err++;
        $display("FAIL rand_do i=%0d a=%0d: got %h expected %h", i, io_a, do16, exp_do);
      end
      n_cmp++;
      if (irq16 !== m_irq()) begin
        n_err++;
        $display("FAIL rand_irq i=%0d: got %b expected %b", i, irq16, m_irq());
      end
      n_cmp++;
      if (pwm16 !== m_pwm) begin
        n_err++;
        $display("FAIL rand_pwm i=%0d: got %b expected %b", i, pwm16, m_pwm);
      end
      edge_step();
      rst = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; io_re = 1'b0; io_we = 1'b0; io_a = 3'd0; io_di = 8'h00;
    m_cnt = 0; m_tmp = 0; m_tcr = 0; m_tsr = 0; m_ocr0 = 0; m_ocr1 = 0;
    m_top = 32'hFFFF; m_elapsed = 0; m_pwm = 2'b00;
    test_reset();
    test_ctc_wrap();
    test_atomic16();
    test_prescaler();
    test_pwm();
    test_flag_collision();
    test_reset_mid_count();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
